ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 165 ++++++++++++++++
 tb/tb_ex_operand_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: operand resolution stage in front of the ALU.
// A two-entry elastic buffer (output register + skid register) that captures
// ALU operands with MEM/WB forwarding resolved in the accept cycle.
// Ports:
//   clk, reset                    clock, async active-high reset
//   in_valid / in_ready           upstream handshake
//   in_rs1_data, in_rs2_data      register-file read data
//   in_imm, in_alu_src            immediate and operand-B select
//   in_alu_control, in_rd,
//   in_reg_write                  passed through unmodified
//   in_rs1, in_rs2                source indices used for forwarding
//   flush                         discard held and incoming entries
//   fwd_mem_*, fwd_wb_*           forwarding sources (MEM has priority)
//   out_valid / out_ready         downstream handshake
//   out_a, out_b, out_alu_control,
//   out_rd, out_reg_write         ALU-stage payload
//   stall_count                   saturating back-pressure cycle counter
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic        in_alu_src,
  input  logic [2:0]  in_alu_control,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        flush,
  input  logic        fwd_mem_valid,
  input  logic        fwd_wb_valid,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic [31:0] fwd_wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [2:0]  out_alu_control,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic [15:0] stall_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CTL_W  = 3;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // Field order matches the output concatenation used when loading the output register.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [CTL_W-1:0]  ctl;
    logic [IDX_W-1:0]  rd;
    logic              rw;
  } entry_t;

  state_t state;
  entry_t skid;
  entry_t cap_c;
  logic   accept_c;
  logic   fire_c;

  // Forwarding mux: MEM beats WB, index 0 is never forwarded.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] rf_data,
    input logic              mem_v,
    input logic [IDX_W-1:0]  mem_rd,
    input logic [DATA_W-1:0] mem_data,
    input logic              wb_v,
    input logic [IDX_W-1:0]  wb_rd,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] r;
    r = rf_data;
    if (idx != '0) begin
      if (mem_v && (mem_rd == idx))     r = mem_data;
      else if (wb_v && (wb_rd == idx))  r = wb_data;
    end
    return r;
  endfunction

  // in_ready is forced low while reset is held, independent of the clock.
  assign in_ready = (state != TWO) && !reset;
  assign accept_c = in_valid && in_ready;
  assign fire_c   = out_valid && out_ready;

  // Entry as it would be captured this cycle.
  always_comb begin
    cap_c     = '0;
    cap_c.a   = resolve(in_rs1, in_rs1_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    cap_c.b   = in_alu_src ? in_imm
                           : resolve(in_rs2, in_rs2_data, fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                                     fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    cap_c.ctl = in_alu_control;
    cap_c.rd  = in_rd;
    cap_c.rw  = in_reg_write;
  end

  // Buffer state, payload registers and stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= EMPTY;
      out_valid       <= 1'b0;
      out_a           <= '0;
      out_b           <= '0;
      out_alu_control <= '0;
      out_rd          <= '0;
      out_reg_write   <= 1'b0;
      skid            <= '0;
      stall_count     <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);

      // Flush empties the buffer; payload registers keep their last value.
      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end else begin
        case (state)
          EMPTY: begin
            if (accept_c) begin
              {out_a, out_b, out_alu_control, out_rd, out_reg_write} <= cap_c;
              state     <= ONE;
              out_valid <= 1'b1;
            end
          end
          ONE: begin
            if (accept_c && fire_c) begin
              {out_a, out_b, out_alu_control, out_rd, out_reg_write} <= cap_c;
            end else if (accept_c) begin
              skid  <= cap_c;
              state <= TWO;
            end else if (fire_c) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          TWO: begin
            // in_ready is low here, so only a fire can move the buffer.
            if (fire_c) begin
              {out_a, out_b, out_alu_control, out_rd, out_reg_write} <= skid;
              state <= ONE;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed steps with a scoreboard queue
// modelling the two-entry buffer, forwarding and the stall counter.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_alu_src;
  logic [2:0]  in_alu_control;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_reg_write;
  logic        flush;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_alu_control;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_alu_control(in_alu_control),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .flush(flush),
    .fwd_mem_valid(fwd_mem_valid), .fwd_wb_valid(fwd_wb_valid),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_control(out_alu_control),
    .out_rd(out_rd), .out_reg_write(out_reg_write),
    .stall_count(stall_count)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  logic [15:0] m_stall;
  logic        last_acc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_res(input logic [4:0] idx, input logic [31:0] rf);
    if (fwd_mem_valid && fwd_mem_rd == idx && idx != 5'd0) return fwd_mem_data;
    if (fwd_wb_valid && fwd_wb_rd == idx && idx != 5'd0) return fwd_wb_data;
    return rf;
  endfunction

  task automatic drive(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic src, input logic [2:0] ctl, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
    in_alu_src = src; in_alu_control = ctl; in_rs1 = r1; in_rs2 = r2;
    in_rd = rd; in_reg_write = rw;
  endtask

  task automatic set_fwd(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
    fwd_mem_valid = mv; fwd_mem_rd = mrd; fwd_mem_data = md;
    fwd_wb_valid = wv; fwd_wb_rd = wrd; fwd_wb_data = wd;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Called at posedge+1: check outputs mid-cycle, advance the model, step one edge.
  task automatic cycle();
    exp_t cur;
    logic acc, fire;
    #3;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) last = q[0];
    chk("out_a", out_a, last.a);
    chk("out_b", out_b, last.b);
    chk("out_alu_control", 32'(out_alu_control), 32'(last.ctl));
    chk("out_rd", 32'(out_rd), 32'(last.rd));
    chk("out_reg_write", 32'(out_reg_write), 32'(last.rw));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    acc  = in_valid && (q.size() < 2);
    fire = (q.size() != 0) && out_ready;
    if (q.size() != 0 && !out_ready && m_stall != 16'hFFFF) m_stall++;
    cur.a   = m_res(in_rs1, in_rs1_data);
    cur.b   = in_alu_src ? in_imm : m_res(in_rs2, in_rs2_data);
    cur.ctl = in_alu_control;
    cur.rd  = in_rd;
    cur.rw  = in_reg_write;
    if (flush) q.delete();
    else begin
      if (fire) q.delete(0);
      if (acc) q.push_back(cur);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; idle();
    drive(32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    last = '0; m_stall = '0; last_acc = 1'b0;

    // Reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Passthrough, one-cycle latency
    out_ready = 1'b1;
    drive(32'd5, 32'd7, 32'd0, 1'b0, 3'b000, 5'd1, 5'd2, 5'd9, 1'b1);
    cycle();
    chk("pass_valid", 32'(out_valid), 32'd1);
    chk("pass_a", out_a, 32'd5);
    chk("pass_b", out_b, 32'd7);
    chk("pass_ctl", 32'(out_alu_control), 32'd0);

    // MEM beats WB on rs1
    drive(32'h1111, 32'h2222, 32'd0, 1'b0, 3'b010, 5'd3, 5'd6, 5'd10, 1'b1);
    set_fwd(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    cycle();
    chk("fwd_mem_prio", out_a, 32'hAAAA);

    // Index 0 never forwarded
    drive(32'h3333, 32'h4444, 32'd0, 1'b0, 3'b011, 5'd0, 5'd0, 5'd11, 1'b0);
    set_fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
    cycle();
    chk("fwd_zero_a", out_a, 32'h3333);
    chk("fwd_zero_b", out_b, 32'h4444);

    // WB forwarding on rs2
    drive(32'h5555, 32'h6666, 32'd0, 1'b0, 3'b100, 5'd7, 5'd5, 5'd12, 1'b1);
    set_fwd(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd5, 32'hCCCC);
    cycle();
    chk("fwd_wb_b", out_b, 32'hCCCC);

    // Immediate wins over forwarded rs2
    drive(32'h7777, 32'h8888, 32'hFFFFFFFC, 1'b1, 3'b101, 5'd8, 5'd4, 5'd13, 1'b1);
    set_fwd(1'b1, 5'd4, 32'hDDDD, 1'b1, 5'd4, 32'hEEEE);
    cycle();
    chk("imm_b", out_b, 32'hFFFFFFFC);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle();
    cycle();
    cycle();

    // Back-pressure: three entries, in-order delivery
    out_ready = 1'b0;
    drive(32'd101, 32'd201, 32'd0, 1'b0, 3'b001, 5'd1, 5'd2, 5'd1, 1'b1);
    cycle();
    drive(32'd102, 32'd202, 32'd0, 1'b0, 3'b010, 5'd1, 5'd2, 5'd2, 1'b0);
    cycle();
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    drive(32'd103, 32'd203, 32'd0, 1'b0, 3'b110, 5'd1, 5'd2, 5'd3, 1'b1);
    cycle();
    cycle();
    chk("bp_stall_count", 32'(stall_count), 32'd3);
    out_ready = 1'b1;
    cycle();
    chk("bp_e3_held_off", 32'(last_acc), 32'd0);
    cycle();
    chk("bp_e3_accepted", 32'(last_acc), 32'd1);
    idle();
    cycle();
    cycle();

    // Flush with both entries held plus a same-cycle accept
    out_ready = 1'b0;
    drive(32'd301, 32'd401, 32'd0, 1'b0, 3'b001, 5'd1, 5'd2, 5'd4, 1'b1);
    cycle();
    drive(32'd302, 32'd402, 32'd0, 1'b0, 3'b010, 5'd1, 5'd2, 5'd5, 1'b1);
    cycle();
    drive(32'd303, 32'd403, 32'd0, 1'b0, 3'b011, 5'd1, 5'd2, 5'd6, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cycle();
    cycle();

    // Async reset between edges while holding two entries
    out_ready = 1'b0;
    drive(32'd501, 32'd601, 32'd0, 1'b0, 3'b111, 5'd1, 5'd2, 5'd7, 1'b1);
    cycle();
    drive(32'd502, 32'd602, 32'd0, 1'b0, 3'b110, 5'd1, 5'd2, 5'd8, 1'b1);
    cycle();
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_a", out_a, 32'd0);
    chk("arst_out_b", out_b, 32'd0);
    chk("arst_ctl", 32'(out_alu_control), 32'd0);
    chk("arst_rd", 32'(out_rd), 32'd0);
    chk("arst_rw", 32'(out_reg_write), 32'd0);
    chk("arst_stall", 32'(stall_count), 32'd0);
    q.delete(); last = '0; m_stall = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle();

    // Stall counter saturation
    drive(32'd701, 32'd801, 32'd0, 1'b0, 3'b001, 5'd1, 5'd2, 5'd9, 1'b1);
    cycle();
    idle();
    repeat (70000) @(posedge clk);
    #1;
    m_stall = 16'hFFFF;
    chk("stall_saturated", 32'(stall_count), 32'h0000FFFF);
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
